i2s_transmitter: RTL and testbench

- Playback-side serializer: accepts 24-bit left/right sample pairs with a valid/ready handshake and drives an I2S master stream (BCLK, LRCLK, SDATA) to the codec DAC.
- Complements the capture path that produces `i_data_left`/`i_data_right`/`i_data_valid` for `led_meter` and the processing chain.
- Includes a one-pair holding register so upstream can deliver samples anywhere within a frame.

---
 rtl/audio_pkg.sv | 15 +
 rtl/i2s_clock_gen.sv | 55 +++++
 rtl/i2s_transmitter.sv | 103 ++++++++++
 tb/tb_i2s_transmitter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample types for the I2S audio path.
// Default widths for the transmitter and future receiver.
package audio_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_SLOT_WIDTH = 32;

  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: BCLK divider and frame bit counter for an I2S master.
// LRCLK and the fall strobe move together on the BCLK falling edge.
module i2s_clock_gen #(
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_HALF  = 4,
  localparam int BW = $clog2(2 * SLOT_WIDTH),
  localparam int CW = $clog2(BCLK_HALF)
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  output logic          o_bclk,
  output logic          o_fall,
  output logic          o_wrap,
  output logic [BW-1:0] o_bit_nxt,
  output logic          o_lrclk
);

  localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] R_FIRST  = BW'(SLOT_WIDTH);

  logic [CW-1:0] div_q;
  logic [BW-1:0] bit_q;
  logic          div_term;

  assign div_term  = (div_q == DIV_LAST);
  assign o_fall    = div_term & o_bclk;
  assign o_wrap    = o_fall & (bit_q == BIT_LAST);
  assign o_bit_nxt = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;

  // Half-period divider; BCLK toggles on terminal count.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q  <= '0;
      o_bclk <= 1'b0;
    end else if (div_term) begin
      div_q  <= '0;
      o_bclk <= ~o_bclk;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Bit position and word select advance on each BCLK fall.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_q   <= BIT_LAST;
      o_lrclk <= 1'b0;
    end else if (o_fall) begin
      bit_q   <= o_bit_nxt;
      o_lrclk <= (o_bit_nxt >= R_FIRST);
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: stereo sample serializer driving an I2S DAC.
// One-pair holding register decouples upstream from frame timing.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
  parameter int BCLK_HALF  = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data_left,
  input  logic [DATA_WIDTH-1:0] i_data_right,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  output logic                  o_underrun
);

  localparam int BW = $clog2(2 * SLOT_WIDTH);

  localparam logic [BW-1:0] L_MSB  = BW'(1);
  localparam logic [BW-1:0] L_LSB  = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] R_LOAD = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0] R_MSB  = BW'(SLOT_WIDTH + 1);
  localparam logic [BW-1:0] R_LSB  = BW'(SLOT_WIDTH + DATA_WIDTH);

  logic          fall;
  logic          wrap;
  logic [BW-1:0] bit_nxt;
  logic          hold_full;
  logic          accept;
  logic          in_data;
  stereo_t       hold_q;
  stereo_t       frame_q;
  sample_t       shift_q;

  i2s_clock_gen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_HALF  (BCLK_HALF)
  ) u_clock_gen (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .o_bclk    (o_bclk),
    .o_fall    (fall),
    .o_wrap    (wrap),
    .o_bit_nxt (bit_nxt),
    .o_lrclk   (o_lrclk)
  );

  assign hold_full = ~o_data_ready;
  assign accept    = i_data_valid & o_data_ready;
  assign in_data   = (bit_nxt >= L_MSB && bit_nxt <= L_LSB)
                   | (bit_nxt >= R_MSB && bit_nxt <= R_LSB);

  // Holding register: fill on handshake, drain on frame load.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hold_q       <= '0;
      o_data_ready <= 1'b1;
    end else if (accept) begin
      hold_q.left  <= i_data_left;
      hold_q.right <= i_data_right;
      o_data_ready <= 1'b0;
    end else if (wrap && hold_full) begin
      o_data_ready <= 1'b1;
    end
  end

  // Frame load, underrun flag and MSB-first serializer.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_q    <= '0;
      shift_q    <= '0;
      o_sdata    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= wrap & ~hold_full;
      if (wrap) begin
        o_sdata <= 1'b0;
        if (hold_full) begin
          frame_q <= hold_q;
          shift_q <= hold_q.left;
        end else begin
          shift_q <= frame_q.left;
        end
      end else if (fall) begin
        if (bit_nxt == R_LOAD) begin
          shift_q <= frame_q.right;
          o_sdata <= 1'b0;
        end else if (in_data) begin
          o_sdata <= shift_q[DATA_WIDTH-1];
          shift_q <= shift_q << 1;
        end else begin
          o_sdata <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: directed and random stimulus for i2s_transmitter
// against a cycle-count model of the I2S frame and holding register.
`timescale 1ns/1ps
module tb_i2s_transmitter;

  localparam int DW        = 24;
  localparam int SW        = 32;
  localparam int BH        = 4;
  localparam int FRAME     = 2 * SW;
  localparam int BITC      = 2 * BH;
  localparam int FRAME_CYC = FRAME * BITC;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] d_l   = '0;
  logic [DW-1:0] d_r   = '0;
  logic          d_v   = 1'b0;
  logic          rdy;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          ur;

  int checks   = 0;
  int failures = 0;

  i2s_transmitter #(
    .DATA_WIDTH (DW),
    .SLOT_WIDTH (SW),
    .BCLK_HALF  (BH)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_data_left  (d_l),
    .i_data_right (d_r),
    .i_data_valid (d_v),
    .o_data_ready (rdy),
    .o_bclk       (bclk),
    .o_lrclk      (lrclk),
    .o_sdata      (sdata),
    .o_underrun   (ur)
  );

  always #5 clk = ~clk;

  // reference model state
  int            cyc;
  int            cur_bit;
  bit            started;
  bit            m_full;
  bit            m_acc;
  logic [DW-1:0] m_hold_l, m_hold_r;
  logic [DW-1:0] m_frm_l, m_frm_r;
  // observation state
  logic          prev_bclk;
  bit            fell;
  logic [DW-1:0] dec_l, dec_r, last_l, last_r;
  int            dec_frames = 0;
  int            ur_seen    = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    cur_bit   = 0;
    started   = 0;
    m_full    = 0;
    m_acc     = 0;
    m_hold_l  = '0;
    m_hold_r  = '0;
    m_frm_l   = '0;
    m_frm_r   = '0;
    prev_bclk = 1'b0;
    dec_l     = '0;
    dec_r     = '0;
  endtask

  function automatic bit is_load(input int c);
    return c > 0 && c % BITC == 0 && ((c / BITC - 1) % FRAME) == 0;
  endfunction

  // one clock: advance model, compare all outputs, decode serial stream
  task automatic step();
    bit            e_bclk, e_lr, e_sd, e_ur, e_rdy;
    logic [DW-1:0] tmp;
    @(posedge clk);
    #1;
    m_acc = 0;
    fell  = 0;
    e_ur  = 0;
    e_sd  = 0;
    if (!rst_n) begin
      model_reset();
      e_bclk = 0;
      e_lr   = 0;
      e_rdy  = 1;
    end else begin
      cyc++;
      m_acc = d_v && !m_full;
      if (cyc % BITC == 0) begin
        started = 1;
        cur_bit = (cyc / BITC - 1) % FRAME;
        if (cur_bit == 0) begin
          if (m_full) begin
            m_frm_l = m_hold_l;
            m_frm_r = m_hold_r;
            m_full  = 0;
          end else begin
            e_ur = 1;
          end
        end
      end
      if (m_acc) begin
        m_hold_l = d_l;
        m_hold_r = d_r;
        m_full   = 1;
      end
      e_bclk = ((cyc / BH) % 2) == 1;
      e_lr   = started && cur_bit >= SW;
      if (started && cur_bit >= 1 && cur_bit <= DW) begin
        tmp  = m_frm_l >> (DW - cur_bit);
        e_sd = tmp[0];
      end else if (started && cur_bit >= SW + 1 && cur_bit <= SW + DW) begin
        tmp  = m_frm_r >> (SW + DW - cur_bit);
        e_sd = tmp[0];
      end
      e_rdy = !m_full;
    end
    chk("bclk", 64'(bclk), 64'(e_bclk));
    chk("lrclk", 64'(lrclk), 64'(e_lr));
    chk("sdata", 64'(sdata), 64'(e_sd));
    chk("underrun", 64'(ur), 64'(e_ur));
    chk("ready", 64'(rdy), 64'(e_rdy));
    if (rst_n) begin
      if (bclk && !prev_bclk && started) begin
        if (cur_bit >= 1 && cur_bit <= DW)
          dec_l = {dec_l[DW-2:0], sdata};
        else if (cur_bit >= SW + 1 && cur_bit <= SW + DW)
          dec_r = {dec_r[DW-2:0], sdata};
        if (cur_bit == FRAME - 1) begin
          chk("frame_left", 64'(dec_l), 64'(m_frm_l));
          chk("frame_right", 64'(dec_r), 64'(m_frm_r));
          last_l = dec_l;
          last_r = dec_r;
          dec_frames++;
        end
      end
      fell = prev_bclk && !bclk;
      if (ur) ur_seen++;
      prev_bclk = bclk;
    end
  endtask

  task automatic run_frames(input int n, input bit churn);
    int target = dec_frames + n;
    int budget = (n + 1) * FRAME_CYC;
    while (dec_frames < target && budget > 0) begin
      step();
      budget--;
      if (churn) begin
        d_l = DW'($urandom);
        d_r = DW'($urandom);
      end
    end
    chk("frames_timeout", 64'(dec_frames >= target), 64'(1));
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int budget = 2 * FRAME_CYC;
    d_l = l;
    d_r = r;
    d_v = 1'b1;
    do begin
      step();
      budget--;
    end while (!m_acc && budget > 0);
    d_v = 1'b0;
    chk("send_timeout", 64'(m_acc), 64'(1));
  endtask

  initial begin
    int            n;
    int            guard;
    int            u0;
    int            acc_cnt;
    int            k;
    logic [DW-1:0] pl, pr;

    model_reset();
    repeat (3) step();

    // first frame with nothing queued: zeros and underrun
    rst_n = 1'b1;
    guard = 0;
    while (!started && guard < 64) begin
      step();
      guard++;
    end
    chk("first_frame_underrun", 64'(ur), 64'(1));
    send(DW'($urandom), DW'($urandom));

    // run to bit 20 with bclk high, then async reset mid-cycle
    guard = 0;
    while (!(started && cur_bit == 20) && guard < 2 * FRAME_CYC) begin
      step();
      guard++;
    end
    repeat (BH) step();
    chk("pre_rst_bclk", 64'(bclk), 64'(1));
    chk("pre_rst_ready", 64'(rdy), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bclk", 64'(bclk), 64'(0));
    chk("rst_lrclk", 64'(lrclk), 64'(0));
    chk("rst_sdata", 64'(sdata), 64'(0));
    chk("rst_underrun", 64'(ur), 64'(0));
    chk("rst_ready", 64'(rdy), 64'(1));
    model_reset();
    repeat (2) step();

    // release with A5/5A pair offered before the first fall
    rst_n = 1'b1;
    d_l   = 24'hA5A5A5;
    d_r   = 24'h5A5A5A;
    d_v   = 1'b1;
    n     = 0;
    do begin
      step();
      n++;
      d_v = 1'b0;
    end while (!fell && n < 32);
    chk("first_fall_cycles", 64'(n), 64'(BITC));
    chk("first_fall_lrclk", 64'(lrclk), 64'(0));
    chk("a5_no_underrun", 64'(ur), 64'(0));
    u0 = ur_seen;
    run_frames(1, 0);
    chk("a5_left", 64'(last_l), 64'(24'hA5A5A5));
    chk("a5_right", 64'(last_r), 64'(24'h5A5A5A));
    chk("a5_underruns", 64'(ur_seen - u0), 64'(0));

    // continuous ramp stream, valid held high throughout
    k   = 1;
    d_l = DW'(k);
    d_r = DW'(k + 'h100000);
    d_v = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      acc_cnt = 0;
      guard   = 0;
      n       = dec_frames + 1;
      while (dec_frames < n && guard < 2 * FRAME_CYC) begin
        step();
        guard++;
        if (m_acc) begin
          acc_cnt++;
          k++;
          d_l = DW'(k);
          d_r = DW'(k + 'h100000);
        end
      end
      chk("ramp_left", 64'(last_l), 64'(f));
      chk("ramp_right", 64'(last_r), 64'(f + 'h100000));
      chk("ramp_accepts", 64'(acc_cnt), 64'(f == 1 ? 2 : 1));
    end
    d_v = 1'b0;

    // stop feeding after full-scale pair: it repeats with underruns
    send(24'h800000, 24'h7FFFFF);
    run_frames(1, 0);
    chk("ramp_tail", 64'(last_l), 64'(5));
    run_frames(1, 0);
    u0 = ur_seen;
    run_frames(3, 0);
    chk("repeat_underruns", 64'(ur_seen - u0), 64'(3));
    chk("repeat_left", 64'(last_l), 64'(24'h800000));
    chk("repeat_right", 64'(last_r), 64'(24'h7FFFFF));

    // valid raised exactly on a load edge with hold empty
    guard = 0;
    while (!is_load(cyc + 1) && guard < 2 * FRAME_CYC) begin
      step();
      guard++;
    end
    pl  = DW'($urandom);
    pr  = DW'($urandom);
    d_l = pl;
    d_r = pr;
    d_v = 1'b1;
    step();
    chk("lc_underrun", 64'(ur), 64'(1));
    chk("lc_ready", 64'(rdy), 64'(0));

    // keep valid high with changing data while not ready
    run_frames(1, 1);
    chk("lc_cur_left", 64'(last_l), 64'(24'h800000));
    run_frames(1, 1);
    chk("held_left", 64'(last_l), 64'(pl));
    chk("held_right", 64'(last_r), 64'(pr));
    d_v = 1'b0;

    // random sparse traffic
    guard = 0;
    n     = dec_frames + 6;
    while (dec_frames < n && guard < 8 * FRAME_CYC) begin
      step();
      guard++;
      d_v = ($urandom_range(0, 255) == 0);
      d_l = DW'($urandom);
      d_r = DW'($urandom);
    end
    chk("random_frames", 64'(dec_frames >= n), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
